hazard_stall_controller: RTL and testbench
==========================================

Name: hazard_stall_controller

Overview:
Parametrised pipeline hazard controller for the 5-stage core. It generalises the single-cycle load-use stall in four ways: configurable data-memory load latency, multi-cycle mul/div occupancy of EX, taken-branch flush, and x0/unused-operand filtering. Detection is combinational in the detect cycle; multi-cycle stalls are held by an internal FSM and down-counter. The block also keeps a saturating stall-cycle performance counter. It sits beside the ID and EX stages and drives the PC/IF-ID enables, the ID/EX bubble select and the EX hold.

Parameters:
REG_ADDR_W, 5, register index width.
LOAD_LAT, 1, load-use stall cycles; legal range 1..8. A value of 1 gives single-cycle stall behaviour.
MD_LAT, 4, EX occupancy in cycles of a mul/div op; legal range 1..32. Stall length is MD_LAT-1.
PERF_W, 16, stall counter width.

Ports:
clk  in  1  core clock, rising edge.
rst  in  1  synchronous active-high reset.
DMRd_ex  in  1  EX-stage instruction is a load.
rd_ex  in  REG_ADDR_W  EX-stage destination register.
rs1_de  in  REG_ADDR_W  ID-stage source 1.
rs2_de  in  REG_ADDR_W  ID-stage source 2.
rs1_used_de  in  1  ID instruction actually reads rs1.
rs2_used_de  in  1  ID instruction actually reads rs2.
md_start_ex  in  1  first EX cycle of a mul/div op.
branch_taken_ex  in  1  branch/jump resolved taken in EX.
perf_clr  in  1  synchronous clear of stall_cnt.
stall_fd  out  1  hold PC and IF/ID.
bubble_ex  out  1  load NOP into ID/EX.
stall_ex  out  1  hold ID/EX and EX (mul/div in progress).
flush_fd  out  1  squash IF/ID contents.
busy  out  1  FSM not IDLE.
stall_cnt  out  PERF_W  cycles with stall_fd=1, saturating.

Behaviour:
- States: IDLE, LD_WAIT, MD_BUSY. Remaining-cycle counter rem, width clog2(max(LOAD_LAT,MD_LAT))+1.
- load_use = DMRd_ex & (rd_ex!=0) & ((rs1_used_de & rs1_de==rd_ex) | (rs2_used_de & rs2_de==rd_ex)).
- Outputs are combinational from state and inputs. All outputs are 0 while rst=1.
- IDLE priority: branch_taken_ex > md_start_ex > load_use.
  - branch_taken_ex: flush_fd=1, bubble_ex=1, stall_fd=0. Stay in IDLE.
  - md_start_ex with MD_LAT>1: stall_fd=1, stall_ex=1, bubble_ex=0. If MD_LAT>2, go to MD_BUSY with rem=MD_LAT-2; otherwise stay in IDLE.
  - md_start_ex with MD_LAT=1: no effect.
  - load_use: stall_fd=1, bubble_ex=1. If LOAD_LAT>1, go to LD_WAIT with rem=LOAD_LAT-1; otherwise stay in IDLE.
- LD_WAIT: stall_fd=1, bubble_ex=1. All hazard inputs are ignored. If rem==1, go to IDLE; otherwise rem-1.
- MD_BUSY: stall_fd=1, stall_ex=1. All hazard inputs are ignored. If rem==1, go to IDLE; otherwise rem-1.
- On return to IDLE, load_use is re-evaluated in that same cycle. This permits back-to-back hazards.
- busy = (state!=IDLE).
- stall_cnt:
  - Increments by 1 on each clock edge where stall_fd=1 and rst=0.
  - Saturates at 2^PERF_W-1.
  - perf_clr has priority over increment; the next value is 0.
  - rst clears the counter to 0.
- Reset mid-stall: the next state is IDLE, rem=0 and all stall outputs drop in the reset cycle. There is no residual stall after reset.
- rd_ex=0 never stalls, even when DMRd_ex=1 and the sources match.

Test Plan:
- LOAD_LAT=1: DMRd_ex=1, rd_ex=5, rs1_de=5, rs1_used_de=1 for 1 cycle -> stall_fd=bubble_ex=1 for exactly 1 cycle, busy stays 0, stall_cnt=1.
- LOAD_LAT=3, same load-use -> stall_fd=bubble_ex=1 for 3 consecutive cycles, busy=1 in cycles 2-3, then IDLE. rd_ex=0 or rs2_used_de=0 with only rs2 matching -> no stall.
- MD_LAT=4: md_start_ex pulse -> stall_fd=stall_ex=1 for 3 cycles, bubble_ex=0. MD_LAT=1 -> no stall.
- branch_taken_ex=1 together with load_use -> flush_fd=1, bubble_ex=1, stall_fd=0, stall_cnt unchanged.
- LOAD_LAT=3: assert rst in the 2nd stall cycle -> all outputs 0 that cycle, state IDLE, stall_cnt=0 after the edge.
- PERF_W=4: 20 stall cycles -> stall_cnt holds 15. perf_clr during a stall -> stall_cnt=0 next cycle, then resumes counting.

Source files
------------

// File: rtl/hazard_stall_controller_if.sv
// Hazard controller bundle between the ID/EX stage logic and the stall controller.
//   master : pipeline side, drives hazard sources, receives stall/flush controls.
//   slave  : hazard_stall_controller side.
// Signals
//   DMRd_ex, rd_ex                 EX-stage load flag and destination register
//   rs1_de, rs2_de                 ID-stage source registers
//   rs1_used_de, rs2_used_de       ID instruction actually reads the source
//   md_start_ex                    first EX cycle of a mul/div op
//   branch_taken_ex                branch/jump resolved taken in EX
//   perf_clr                       clear the stall-cycle counter
//   stall_fd, bubble_ex, stall_ex  PC/IF-ID hold, ID/EX NOP select, EX hold
//   flush_fd, busy, stall_cnt      IF/ID squash, FSM active, stall-cycle count
interface hazard_stall_controller_if #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned PERF_W     = 16
);
    logic                  DMRd_ex;
    logic [REG_ADDR_W-1:0] rd_ex;
    logic [REG_ADDR_W-1:0] rs1_de;
    logic [REG_ADDR_W-1:0] rs2_de;
    logic                  rs1_used_de;
    logic                  rs2_used_de;
    logic                  md_start_ex;
    logic                  branch_taken_ex;
    logic                  perf_clr;
    logic                  stall_fd;
    logic                  bubble_ex;
    logic                  stall_ex;
    logic                  flush_fd;
    logic                  busy;
    logic [PERF_W-1:0]     stall_cnt;

    modport master (
        output DMRd_ex, rd_ex, rs1_de, rs2_de, rs1_used_de, rs2_used_de,
        output md_start_ex, branch_taken_ex, perf_clr,
        input  stall_fd, bubble_ex, stall_ex, flush_fd, busy, stall_cnt
    );

    modport slave (
        input  DMRd_ex, rd_ex, rs1_de, rs2_de, rs1_used_de, rs2_used_de,
        input  md_start_ex, branch_taken_ex, perf_clr,
        output stall_fd, bubble_ex, stall_ex, flush_fd, busy, stall_cnt
    );
endinterface

// File: rtl/hazard_stall_controller.sv
// Pipeline hazard controller for the 5-stage core: load-use stalls with a configurable
// load latency, multi-cycle mul/div EX occupancy, taken-branch flush and a saturating
// stall-cycle counter. Hazards are detected combinationally; multi-cycle stalls are held
// by a small FSM with a remaining-cycle down-counter.
// Ports
//   clk  : core clock, rising edge
//   rst  : synchronous active-high reset; forces all outputs to 0 while asserted
//   hz   : hazard bundle (slave modport), see hazard_stall_controller_if
module hazard_stall_controller #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned LOAD_LAT   = 1,
    parameter int unsigned MD_LAT     = 4,
    parameter int unsigned PERF_W     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    hazard_stall_controller_if.slave hz
);
    localparam int unsigned MaxLat = (LOAD_LAT > MD_LAT) ? LOAD_LAT : MD_LAT;
    localparam int unsigned RemW   = $clog2(MaxLat) + 1;
    // First cycle of each stall happens in IDLE, so the counter covers the remainder.
    localparam logic [RemW-1:0] LdInit = RemW'((LOAD_LAT > 1) ? LOAD_LAT - 1 : 0);
    localparam logic [RemW-1:0] MdInit = RemW'((MD_LAT > 2) ? MD_LAT - 2 : 0);

    typedef enum logic [1:0] {StIdle, StLdWait, StMdBusy} state_e;

    state_e            state_q, state_d;
    logic [RemW-1:0]   rem_q, rem_d;
    logic [PERF_W-1:0] cnt_q, cnt_d;

    logic load_use;
    logic stall_fd, bubble_ex, stall_ex, flush_fd;

    // rd_ex == 0 is x0 and never creates a dependency.
    assign load_use = hz.DMRd_ex && (hz.rd_ex != '0) &&
                      ((hz.rs1_used_de && (hz.rs1_de == hz.rd_ex)) ||
                       (hz.rs2_used_de && (hz.rs2_de == hz.rd_ex)));

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        stall_fd  = 1'b0;
        bubble_ex = 1'b0;
        stall_ex  = 1'b0;
        flush_fd  = 1'b0;
        if (rst) begin
            state_d = StIdle;
            rem_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (hz.branch_taken_ex) begin
                        // Wrong-path instruction in ID is squashed, not stalled.
                        flush_fd  = 1'b1;
                        bubble_ex = 1'b1;
                    end else if (hz.md_start_ex && (MD_LAT > 1)) begin
                        stall_fd = 1'b1;
                        stall_ex = 1'b1;
                        if (MD_LAT > 2) begin
                            state_d = StMdBusy;
                            rem_d   = MdInit;
                        end
                    end else if (load_use) begin
                        stall_fd  = 1'b1;
                        bubble_ex = 1'b1;
                        if (LOAD_LAT > 1) begin
                            state_d = StLdWait;
                            rem_d   = LdInit;
                        end
                    end
                end
                StLdWait: begin
                    stall_fd  = 1'b1;
                    bubble_ex = 1'b1;
                    if (rem_q == RemW'(1)) begin
                        state_d = StIdle;
                        rem_d   = '0;
                    end else begin
                        rem_d = rem_q - RemW'(1);
                    end
                end
                StMdBusy: begin
                    stall_fd = 1'b1;
                    stall_ex = 1'b1;
                    if (rem_q == RemW'(1)) begin
                        state_d = StIdle;
                        rem_d   = '0;
                    end else begin
                        rem_d = rem_q - RemW'(1);
                    end
                end
                default: begin
                    state_d = StIdle;
                    rem_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (hz.perf_clr) begin
            cnt_d = '0;
        end else if (stall_fd && (cnt_q != '1)) begin
            cnt_d = cnt_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            rem_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
        end
    end

    assign hz.stall_fd  = stall_fd;
    assign hz.bubble_ex = bubble_ex;
    assign hz.stall_ex  = stall_ex;
    assign hz.flush_fd  = flush_fd;
    assign hz.busy      = !rst && (state_q != StIdle);
    assign hz.stall_cnt = rst ? '0 : cnt_q;
endmodule

// File: tb/tb_hazard_stall_controller.sv
// Two controllers share one stimulus stream:
//   A: LOAD_LAT=3, MD_LAT=4, PERF_W=4   B: LOAD_LAT=1, MD_LAT=1, PERF_W=16
// Expected output vectors are {stall_fd, bubble_ex, stall_ex, flush_fd, busy}.
module tb_hazard_stall_controller;
    typedef struct packed {
        logic       rst;
        logic       dmrd;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       md;
        logic       br;
        logic       clr;
    } stim_t;

    typedef struct {
        logic [4:0]  oa;
        logic [3:0]  ca;
        logic [4:0]  ob;
        logic [15:0] cb;
        string       tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];
    logic [3:0]  cnt_a = '0;
    logic [15:0] cnt_b = '0;

    hazard_stall_controller_if #(.REG_ADDR_W(5), .PERF_W(4))  hz_a ();
    hazard_stall_controller_if #(.REG_ADDR_W(5), .PERF_W(16)) hz_b ();

    hazard_stall_controller #(
        .REG_ADDR_W(5), .LOAD_LAT(3), .MD_LAT(4), .PERF_W(4)
    ) u_dut_a (
        .clk (clk),
        .rst (rst),
        .hz  (hz_a)
    );

    hazard_stall_controller #(
        .REG_ADDR_W(5), .LOAD_LAT(1), .MD_LAT(1), .PERF_W(16)
    ) u_dut_b (
        .clk (clk),
        .rst (rst),
        .hz  (hz_b)
    );

    always #5 clk = ~clk;

    function automatic stim_t mk(input logic r, input logic d, input logic [4:0] rd,
                                 input logic [4:0] s1, input logic [4:0] s2, input logic u1,
                                 input logic u2, input logic md, input logic br,
                                 input logic clr);
        stim_t s;
        s.rst = r; s.dmrd = d; s.rd = rd; s.rs1 = s1; s.rs2 = s2;
        s.u1 = u1; s.u2 = u2; s.md = md; s.br = br; s.clr = clr;
        return s;
    endfunction

    // Drive one cycle, queue its expected response, and advance the expected counters.
    task automatic step(input stim_t s, input logic [4:0] ea, input logic [4:0] eb,
                        input string tag);
        exp_t e;
        rst = s.rst;
        hz_a.DMRd_ex = s.dmrd; hz_b.DMRd_ex = s.dmrd;
        hz_a.rd_ex = s.rd;     hz_b.rd_ex = s.rd;
        hz_a.rs1_de = s.rs1;   hz_b.rs1_de = s.rs1;
        hz_a.rs2_de = s.rs2;   hz_b.rs2_de = s.rs2;
        hz_a.rs1_used_de = s.u1; hz_b.rs1_used_de = s.u1;
        hz_a.rs2_used_de = s.u2; hz_b.rs2_used_de = s.u2;
        hz_a.md_start_ex = s.md; hz_b.md_start_ex = s.md;
        hz_a.branch_taken_ex = s.br; hz_b.branch_taken_ex = s.br;
        hz_a.perf_clr = s.clr; hz_b.perf_clr = s.clr;
        e.oa = ea;
        e.ca = s.rst ? 4'd0 : cnt_a;
        e.ob = eb;
        e.cb = s.rst ? 16'd0 : cnt_b;
        e.tag = tag;
        sb.push_back(e);
        if (s.rst || s.clr) begin
            cnt_a = '0;
            cnt_b = '0;
        end else begin
            if (ea[4] && cnt_a != 4'd15) cnt_a = cnt_a + 4'd1;
            if (eb[4] && cnt_b != 16'hffff) cnt_b = cnt_b + 16'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: outputs are valid every cycle, compared away from the active edge.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            check({e.tag, " A.outs"}, 16'({hz_a.stall_fd, hz_a.bubble_ex, hz_a.stall_ex,
                                         hz_a.flush_fd, hz_a.busy}), 16'(e.oa));
            check({e.tag, " A.cnt"}, 16'(hz_a.stall_cnt), 16'(e.ca));
            check({e.tag, " B.outs"}, 16'({hz_b.stall_fd, hz_b.bubble_ex, hz_b.stall_ex,
                                         hz_b.flush_fd, hz_b.busy}), 16'(e.ob));
            check({e.tag, " B.cnt"}, hz_b.stall_cnt, e.cb);
        end
    end

    task automatic load_seq(input stim_t s, input string tag);
        step(s, 5'b11000, 5'b11000, {tag, " c1"});
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 5'b11001, 5'b00000, {tag, " c2"});
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 5'b11001, 5'b00000, {tag, " c3"});
    endtask

    initial begin
        stim_t s0, sr, lu1;
        s0  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        sr  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        lu1 = mk(0, 1, 5, 5, 0, 1, 0, 0, 0, 0);
        hz_a.DMRd_ex = 0; hz_a.rd_ex = 0; hz_a.rs1_de = 0; hz_a.rs2_de = 0;
        hz_a.rs1_used_de = 0; hz_a.rs2_used_de = 0; hz_a.md_start_ex = 0;
        hz_a.branch_taken_ex = 0; hz_a.perf_clr = 0;
        hz_b.DMRd_ex = 0; hz_b.rd_ex = 0; hz_b.rs1_de = 0; hz_b.rs2_de = 0;
        hz_b.rs1_used_de = 0; hz_b.rs2_used_de = 0; hz_b.md_start_ex = 0;
        hz_b.branch_taken_ex = 0; hz_b.perf_clr = 0;
        repeat (2) @(posedge clk);
        #1;

        step(sr, 5'b00000, 5'b00000, "reset");
        step(s0, 5'b00000, 5'b00000, "idle");

        load_seq(lu1, "lu_rs1");
        step(s0, 5'b00000, 5'b00000, "lu_rs1 done");

        step(mk(0, 1, 0, 0, 0, 1, 1, 0, 0, 0), 5'b00000, 5'b00000, "rd_x0");
        step(mk(0, 1, 7, 3, 7, 1, 0, 0, 0, 0), 5'b00000, 5'b00000, "rs2_unused");
        load_seq(mk(0, 1, 7, 3, 7, 1, 1, 0, 0, 0), "lu_rs2");

        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), 5'b10100, 5'b00000, "md c1");
        step(s0, 5'b10101, 5'b00000, "md c2");
        step(s0, 5'b10101, 5'b00000, "md c3");
        step(s0, 5'b00000, 5'b00000, "md done");

        step(mk(0, 1, 5, 5, 0, 1, 0, 0, 1, 0), 5'b01010, 5'b01010, "branch+lu");
        step(s0, 5'b00000, 5'b00000, "branch done");

        // Reset lands in the second stall cycle with the hazard still presented.
        step(lu1, 5'b11000, 5'b11000, "rst_mid c1");
        step(mk(1, 1, 5, 5, 0, 1, 0, 0, 0, 0), 5'b00000, 5'b00000, "rst_mid c2");
        step(s0, 5'b00000, 5'b00000, "rst_mid after");

        step(lu1, 5'b11000, 5'b11000, "b2b c1");
        step(lu1, 5'b11001, 5'b11000, "b2b c2");
        step(lu1, 5'b11001, 5'b11000, "b2b c3");
        step(lu1, 5'b11000, 5'b11000, "b2b c4");
        step(s0, 5'b11001, 5'b00000, "b2b c5");
        step(s0, 5'b11001, 5'b00000, "b2b c6");
        step(s0, 5'b00000, 5'b00000, "b2b done");

        for (int i = 0; i < 5; i++) load_seq(lu1, "sat");
        step(s0, 5'b00000, 5'b00000, "sat hold");
        step(s0, 5'b00000, 5'b00000, "sat hold2");

        step(mk(0, 1, 5, 5, 0, 1, 0, 0, 0, 1), 5'b11000, 5'b11000, "clr c1");
        step(s0, 5'b11001, 5'b00000, "clr c2");
        step(s0, 5'b11001, 5'b00000, "clr c3");
        step(s0, 5'b00000, 5'b00000, "clr resume");

        repeat (3) @(posedge clk);
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain actual=%0d required=0 pending entries", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
